// File: rtl/demux_distributor_if.sv
// Shared-bus interface between the 4:1 channel mux and the demux distributor.
// The master drives the word stream; the slave returns the channel outputs and status strobes.
interface demux_distributor_if #(
   parameter int WIDTH = 3
);
   logic             in_valid;
   logic             mode;
   logic [1:0]       sel;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [3:0]       upd;
   logic [1:0]       rr_ptr;
   logic             frame_done;
   logic             ovr;

   modport master (
      output in_valid, mode, sel, din,
      input  a, b, c, d, upd, rr_ptr, frame_done, ovr
   );

   modport slave (
      input  in_valid, mode, sel, din,
      output a, b, c, d, upd, rr_ptr, frame_done, ovr
   );
endinterface

// File: rtl/demux_distributor.sv
// Distributes one word per valid cycle into four registered channels, either by SEL or by a
// round-robin pointer, and tracks per-frame completion and channel overwrites.
module demux_distributor #(
   parameter int WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   demux_distributor_if.slave  bus
);

   logic [WIDTH-1:0] chan_r [4];
   logic [3:0]       upd_r;
   logic [1:0]       rr_ptr_r;
   logic [3:0]       mask_r;
   logic             frame_done_r;
   logic             ovr_r;

   logic [1:0]       tgt_s;
   logic [3:0]       tgt_oh_s;
   logic             hit_s;
   logic [3:0]       nm_s;
   logic             done_s;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      logic [3:0] oh;
      case (idx)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Target selection and next written-mask; an overwrite leaves the mask untouched.
   always_comb begin
      tgt_s    = 2'd0;
      tgt_oh_s = 4'b0000;
      hit_s    = 1'b0;
      nm_s     = mask_r;
      done_s   = 1'b0;
      if (bus.mode) begin
         tgt_s = rr_ptr_r;
      end else begin
         tgt_s = bus.sel;
      end
      tgt_oh_s = onehot(tgt_s);
      hit_s    = |(mask_r & tgt_oh_s);
      if (hit_s) begin
         nm_s = mask_r;
      end else begin
         nm_s = mask_r | tgt_oh_s;
      end
      done_s = (nm_s == 4'b1111);
   end

   // Channel registers, pointer, mask and single-cycle strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            chan_r[i] <= {WIDTH{1'b0}};
         end
         upd_r        <= 4'b0000;
         rr_ptr_r     <= 2'd0;
         mask_r       <= 4'b0000;
         frame_done_r <= 1'b0;
         ovr_r        <= 1'b0;
      end else if (bus.in_valid) begin
         for (int i = 0; i < 4; i++) begin
            if (tgt_oh_s[i]) begin
               chan_r[i] <= bus.din;
            end
         end
         upd_r <= tgt_oh_s;
         if (bus.mode) begin
            rr_ptr_r <= rr_ptr_r + 2'd1;
         end
         ovr_r        <= hit_s;
         frame_done_r <= done_s;
         // A completed frame clears the mask so the next frame starts empty.
         if (done_s) begin
            mask_r <= 4'b0000;
         end else begin
            mask_r <= nm_s;
         end
      end else begin
         upd_r        <= 4'b0000;
         frame_done_r <= 1'b0;
         ovr_r        <= 1'b0;
      end
   end

   assign bus.a          = chan_r[0];
   assign bus.b          = chan_r[1];
   assign bus.c          = chan_r[2];
   assign bus.d          = chan_r[3];
   assign bus.upd        = upd_r;
   assign bus.rr_ptr     = rr_ptr_r;
   assign bus.frame_done = frame_done_r;
   assign bus.ovr        = ovr_r;

endmodule

// File: tb/tb_demux_distributor.sv
// Directed bench for demux_distributor: hand-computed expectations for reset, addressed and
// round-robin frames, overwrite, idle/mode switching and mid-frame reset.
module tb_demux_distributor;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   demux_distributor_if #(.WIDTH(3)) bus_if ();

   demux_distributor #(.WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic mode, input logic [1:0] sel, input logic [2:0] din);
      @(negedge clk);
      bus_if.mode     = mode;
      bus_if.sel      = sel;
      bus_if.din      = din;
      bus_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      bus_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_strobes(input string tag, input logic [3:0] upd, input logic fd,
                              input logic ovr, input logic [1:0] ptr);
      check_eq({tag, "_upd"}, {4'b0000, bus_if.upd}, {4'b0000, upd});
      check_eq({tag, "_fd"},  {7'b0000000, bus_if.frame_done}, {7'b0000000, fd});
      check_eq({tag, "_ovr"}, {7'b0000000, bus_if.ovr}, {7'b0000000, ovr});
      check_eq({tag, "_ptr"}, {6'b000000, bus_if.rr_ptr}, {6'b000000, ptr});
   endtask

   task automatic chk_chans(input string tag, input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] c, input logic [2:0] d);
      check_eq({tag, "_a"}, {5'b00000, bus_if.a}, {5'b00000, a});
      check_eq({tag, "_b"}, {5'b00000, bus_if.b}, {5'b00000, b});
      check_eq({tag, "_c"}, {5'b00000, bus_if.c}, {5'b00000, c});
      check_eq({tag, "_d"}, {5'b00000, bus_if.d}, {5'b00000, d});
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.mode     = 1'b0;
      bus_if.sel      = 2'b00;
      bus_if.din      = 3'b000;

      // Reset held with a valid word on the bus.
      @(negedge clk);
      rst_n           = 1'b0;
      bus_if.din      = 3'b101;
      bus_if.in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk_chans("rst", 3'b000, 3'b000, 3'b000, 3'b000);
         chk_strobes("rst", 4'b0000, 1'b0, 1'b0, 2'd0);
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      rst_n           = 1'b1;

      // Addressed frame.
      wr(1'b0, 2'b00, 3'b101); chk_strobes("adr1", 4'b0001, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b01, 3'b110); chk_strobes("adr2", 4'b0010, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b10, 3'b010); chk_strobes("adr3", 4'b0100, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b11, 3'b001); chk_strobes("adr4", 4'b1000, 1'b1, 1'b0, 2'd0);
      chk_chans("adr", 3'b101, 3'b110, 3'b010, 3'b001);
      idle();                  chk_strobes("adri", 4'b0000, 1'b0, 1'b0, 2'd0);

      // Round-robin wrap.
      do_reset();
      wr(1'b1, 2'b11, 3'b111); chk_strobes("rr1", 4'b0001, 1'b0, 1'b0, 2'd1);
      wr(1'b1, 2'b00, 3'b010); chk_strobes("rr2", 4'b0010, 1'b0, 1'b0, 2'd2);
      wr(1'b1, 2'b00, 3'b100); chk_strobes("rr3", 4'b0100, 1'b0, 1'b0, 2'd3);
      wr(1'b1, 2'b00, 3'b011); chk_strobes("rr4", 4'b1000, 1'b1, 1'b0, 2'd0);
      chk_chans("rr4", 3'b111, 3'b010, 3'b100, 3'b011);
      wr(1'b1, 2'b00, 3'b001); chk_strobes("rr5", 4'b0001, 1'b0, 1'b0, 2'd1);
      chk_chans("rr5", 3'b001, 3'b010, 3'b100, 3'b011);

      // Overwrite: second B write flags OVR and the frame still needs A, C, D.
      do_reset();
      wr(1'b0, 2'b01, 3'b100); chk_strobes("ov1", 4'b0010, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b01, 3'b011); chk_strobes("ov2", 4'b0010, 1'b0, 1'b1, 2'd0);
      wr(1'b0, 2'b00, 3'b001); chk_strobes("ov3", 4'b0001, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b10, 3'b010); chk_strobes("ov4", 4'b0100, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b11, 3'b111); chk_strobes("ov5", 4'b1000, 1'b1, 1'b0, 2'd0);
      chk_chans("ov", 3'b001, 3'b011, 3'b010, 3'b111);

      // Idle cycles and mode switching share one mask and keep the pointer.
      do_reset();
      wr(1'b1, 2'b00, 3'b101); chk_strobes("md1", 4'b0001, 1'b0, 1'b0, 2'd1);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk_strobes("mdi", 4'b0000, 1'b0, 1'b0, 2'd1);
         chk_chans("mdi", 3'b101, 3'b000, 3'b000, 3'b000);
      end
      wr(1'b0, 2'b11, 3'b100); chk_strobes("md2", 4'b1000, 1'b0, 1'b0, 2'd1);
      wr(1'b1, 2'b11, 3'b011); chk_strobes("md3", 4'b0010, 1'b0, 1'b0, 2'd2);
      chk_chans("md3", 3'b101, 3'b011, 3'b000, 3'b100);
      wr(1'b0, 2'b10, 3'b110); chk_strobes("md4", 4'b0100, 1'b1, 1'b0, 2'd2);

      // Reset mid-frame discards the partial mask.
      do_reset();
      wr(1'b0, 2'b00, 3'b110);
      wr(1'b0, 2'b01, 3'b011);
      chk_chans("mf0", 3'b110, 3'b011, 3'b000, 3'b000);
      do_reset();
      chk_chans("mfr", 3'b000, 3'b000, 3'b000, 3'b000);
      chk_strobes("mfr", 4'b0000, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b10, 3'b001); chk_strobes("mf1", 4'b0100, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b11, 3'b010); chk_strobes("mf2", 4'b1000, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b00, 3'b111); chk_strobes("mf3", 4'b0001, 1'b0, 1'b0, 2'd0);
      wr(1'b0, 2'b01, 3'b101); chk_strobes("mf4", 4'b0010, 1'b1, 1'b0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
